csr_file: RTL

Machine-mode CSR register file and privilege tracker for the single-issue RV64 pipeline. It is the commit-side counterpart to the execute stage. Execute computes CSR write data and raises ECALL/MRET redirects, and this block stores those writes and applies trap/return state changes. It also serves CSR reads to decode and exports `mtvec`/`mepc` plus the current and next privilege level, which feed back into execute's redirect targets.

---
 rtl/csr_file_if.sv | 17 +
 rtl/csr_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/csr_file_if.sv
// csr_file_if: CSR access bus between the decode/commit stages and csr_file.
//   raddr  - CSR read address (decode)
//   rdata  - combinational read data returned by the register file
//   wvalid - commit-stage CSR write enable
//   waddr  - CSR write address
//   wdata  - CSR write data, already merged for RW/RS/RC forms
// Modports: master (pipeline side), slave (csr_file side).
interface csr_file_if;
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic        wvalid;
  logic [11:0] waddr;
  logic [63:0] wdata;

  modport master (output raddr, wvalid, waddr, wdata, input rdata);
  modport slave  (input raddr, wvalid, waddr, wdata, output rdata);
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file and privilege tracker (RV64).
// Stores commit-side CSR writes, applies ECALL/MRET trap and return state,
// serves combinational CSR reads and exports mtvec/mepc and privilege.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   bus (slave)      - raddr/rdata/wvalid/waddr/wdata CSR access bus
//   ecall, mret      - trap / return committing this cycle (ecall wins)
//   pc               - PC of the committing instruction
//   retire           - one instruction retired this cycle
//   mtvec_o, mepc_o  - current mtvec / mepc
//   priv             - current privilege level (0=U, 3=M)
//   priv_nxt         - privilege level taking effect at the next edge
//
// Parameter HARTID: value read back from mhartid (0xF14).
// Build option: define CSR_COUNTERS_EN to implement mcycle/minstret;
// otherwise 0xB00/0xB02 read 0, writes there are dropped, retire is ignored.
module csr_file #(
  parameter logic [63:0] HARTID = '0
) (
  input  logic        clk,
  input  logic        reset,
  csr_file_if.slave   bus,
  input  logic        ecall,
  input  logic        mret,
  input  logic [63:0] pc,
  input  logic        retire,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic [1:0]  priv,
  output logic [1:0]  priv_nxt
);

  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
`endif

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  priv_e       priv_q, priv_d;
  logic        mie_bit_q, mpie_q;
  logic [1:0]  mpp_q;
  logic [63:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q;
  logic [63:0] mcause_q, mtval_q, satp_q;
  logic [63:0] mstatus_rd;
  logic        csr_we;

  // Trap/return commits take priority over the CSR write of the same cycle.
  assign csr_we = bus.wvalid && !ecall && !mret;

  // Reserved MPP encodings (1, 2) return to U.
  function automatic priv_e mret_target(input logic [1:0] mpp);
    return (mpp == 2'b11) ? PRIV_M : PRIV_U;
  endfunction

  always_comb begin
    priv_d = priv_q;
    if (reset)      priv_d = PRIV_M;
    else if (ecall) priv_d = PRIV_M;
    else if (mret)  priv_d = mret_target(mpp_q);
  end

  assign priv     = priv_q;
  assign priv_nxt = priv_d;
  assign mtvec_o  = mtvec_q;
  assign mepc_o   = mepc_q;

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[3]     = mie_bit_q;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[12:11] = mpp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      priv_q     <= PRIV_M;
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
    end else if (ecall) begin
      priv_q    <= PRIV_M;
      mepc_q    <= pc & ~64'h3;
      mcause_q  <= (priv_q == PRIV_U) ? 64'd8 : 64'd11;
      mpie_q    <= mie_bit_q;
      mie_bit_q <= 1'b0;
      mpp_q     <= priv_q;
    end else if (mret) begin
      priv_q    <= mret_target(mpp_q);
      mie_bit_q <= mpie_q;
      mpie_q    <= 1'b1;
      mpp_q     <= PRIV_U;
    end else if (csr_we) begin
      case (bus.waddr)
        CSR_MSTATUS: begin
          mie_bit_q <= bus.wdata[3];
          mpie_q    <= bus.wdata[7];
          mpp_q     <= bus.wdata[12:11];
        end
        CSR_MIE:      mie_q      <= bus.wdata;
        CSR_MIP:      mip_q      <= bus.wdata;
        CSR_MTVEC:    mtvec_q    <= bus.wdata & ~64'h3;
        CSR_MSCRATCH: mscratch_q <= bus.wdata;
        CSR_MEPC:     mepc_q     <= bus.wdata & ~64'h3;
        CSR_MCAUSE:   mcause_q   <= bus.wdata;
        CSR_MTVAL:    mtval_q    <= bus.wdata;
        CSR_SATP:     satp_q     <= bus.wdata;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to a counter replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && bus.waddr == CSR_MCYCLE) mcycle_q <= bus.wdata;
      else                                   mcycle_q <= mcycle_q + 64'd1;
      if (csr_we && bus.waddr == CSR_MINSTRET) minstret_q <= bus.wdata;
      else if (retire)                         minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      CSR_MSTATUS:  bus.rdata = mstatus_rd;
      CSR_MIE:      bus.rdata = mie_q;
      CSR_MIP:      bus.rdata = mip_q;
      CSR_MTVEC:    bus.rdata = mtvec_q;
      CSR_MSCRATCH: bus.rdata = mscratch_q;
      CSR_MEPC:     bus.rdata = mepc_q;
      CSR_MCAUSE:   bus.rdata = mcause_q;
      CSR_MTVAL:    bus.rdata = mtval_q;
      CSR_SATP:     bus.rdata = satp_q;
      CSR_MHARTID:  bus.rdata = HARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   bus.rdata = mcycle_q;
      CSR_MINSTRET: bus.rdata = minstret_q;
`endif
      default:      bus.rdata = '0;
    endcase
  end

endmodule
